// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Handshaked requester front-end for the combinational ALU
//               select unit: latches one op, waits a settle time, returns x.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_sel,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_x,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_sel,
    output logic [WIDTH-1:0] rsp_x,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_sequencer: SETTLE_CYCLES must be within 1..15");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [3:0]       r_alu_sel;
    logic [3:0]       w_alu_sel_nxt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] w_alu_a_nxt;
    logic [WIDTH-1:0] r_alu_b;
    logic [WIDTH-1:0] w_alu_b_nxt;
    logic [3:0]       r_rsp_sel;
    logic [3:0]       w_rsp_sel_nxt;
    logic [WIDTH-1:0] r_rsp_x;
    logic [WIDTH-1:0] w_rsp_x_nxt;
    logic             r_rsp_valid;
    logic             w_rsp_valid_nxt;
    logic [15:0]      r_op_count;
    logic [15:0]      w_op_count_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_alu_sel   <= 4'd0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_sel   <= 4'd0;
            r_rsp_x     <= '0;
            r_rsp_valid <= 1'b0;
            r_op_count  <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_alu_sel   <= w_alu_sel_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_rsp_sel   <= w_rsp_sel_nxt;
            r_rsp_x     <= w_rsp_x_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_op_count  <= w_op_count_nxt;
        end
    end

    // ALU drive registers only move on accept, so the ALU inputs stay
    // quiet from one request to the next.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_alu_sel_nxt   = r_alu_sel;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_rsp_sel_nxt   = r_rsp_sel;
        w_rsp_x_nxt     = r_rsp_x;
        w_rsp_valid_nxt = r_rsp_valid;
        w_op_count_nxt  = r_op_count;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_alu_sel_nxt = req_sel;
                    w_alu_a_nxt   = req_a;
                    w_alu_b_nxt   = req_b;
                    w_rsp_sel_nxt = req_sel;
                    w_cnt_nxt     = c_settle_load;
                    w_state_nxt   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_rsp_x_nxt     = alu_x;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_op_count_nxt  = r_op_count + 16'd1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign alu_sel   = r_alu_sel;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_sel   = r_rsp_sel;
    assign rsp_x     = r_rsp_x;
    assign rsp_valid = r_rsp_valid;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequencing front-end for the 8-bit ALU select unit (4-bit op select, operands a/b, result x). It is the requester side of that interface.
- Accepts one operation request over a valid/ready handshake and drives the ALU operand/select lines from registers.
- Waits a fixed settle time, captures the ALU result, and returns it over a second valid/ready handshake.
- Sits between the datapath controller and the combinational ALU; replaces bench-style free-running stimulus with a paced, handshaked interface.

Parameters:
- WIDTH, 8, operand/result width.
- SETTLE_CYCLES, 1, cycles between driving the ALU and capturing its result. Legal range 1..15; 0 is illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_sel  in  4  ALU op select.
- req_a  in  WIDTH  operand a.
- req_b  in  WIDTH  operand b.
- alu_sel  out  4  to ALU sel.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_x  in  WIDTH  ALU result (combinational from alu_*).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_sel  out  4  op select of the returned result.
- rsp_x  out  WIDTH  captured result.
- op_count  out  16  completed-operation counter.

Behaviour:
- Reset (async, active-high, any state): state=IDLE. req_ready=1 once reset deasserts. rsp_valid=0. alu_sel/alu_a/alu_b/rsp_sel/rsp_x/op_count=0. Settle counter=0. Any in-flight operation is discarded and no response is produced.
- FSM states: IDLE, SETTLE, RESP. All outputs are registered except req_ready, which is 1 iff state==IDLE.
- IDLE: at a clock edge with req_valid&&req_ready:
  - alu_sel/alu_a/alu_b <= req_sel/req_a/req_b and rsp_sel <= req_sel.
  - counter <= SETTLE_CYCLES-1, state -> SETTLE.
  - req_* values are ignored when req_valid=0.
- SETTLE: each edge, if counter!=0 then decrement. If counter==0 then rsp_x <= alu_x, rsp_valid <= 1, state -> RESP.
- Latency: accept at edge E0; rsp_valid rises at edge E0+SETTLE_CYCLES.
- RESP: rsp_valid=1. rsp_x and rsp_sel are held stable until the handshake. At an edge with rsp_ready=1: rsp_valid <= 0, op_count <= op_count+1, state -> IDLE.
- Back-pressure: rsp_ready may stay low indefinitely; the sequencer holds in RESP with req_ready=0.
- Throughput: one op per SETTLE_CYCLES+2 cycles at best, because IDLE costs one cycle after each response. No overlap of requests.
- alu_sel/alu_a/alu_b change only on request accept. They remain stable through SETTLE, RESP and the following IDLE until the next accept.
- op_count wraps 16'hFFFF -> 16'h0000 with no flag.
- rsp_ready while not in RESP: ignored. req_valid while not in IDLE: ignored, and the request must be held by the source (standard valid/ready).
- All sel values 0..15 are passed through unmodified; the sequencer does not interpret them.
- Width: rsp_x is an exact copy of alu_x, with no extension or truncation.

Test Plan:
- Bench ALU stub: alu_x = (alu_a + alu_b) mod 256, combinational.
- Reset mid-SETTLE:
  - Stimulus: SETTLE_CYCLES=4, accept sel=4'b0001, a=8'h01, b=8'h04, assert reset 2 cycles later.
  - Required: immediately rsp_valid=0, alu_a=0, op_count=0, state IDLE. No response ever appears.
- Basic op:
  - Stimulus: SETTLE_CYCLES=1, sel=4'b0011, a=8'h01, b=8'h05, rsp_ready=1.
  - Required: rsp_valid high exactly 1 edge after accept, rsp_x=8'h06, rsp_sel=4'b0011, op_count=1. req_ready returns to 1 one cycle after the handshake.
- Settle timing:
  - Stimulus: SETTLE_CYCLES=3, a=8'hFF, b=8'h7E.
  - Required: rsp_valid rises exactly 3 edges after accept, rsp_x=8'h7D (wrap).
- Back-pressure:
  - Stimulus: rsp_ready=0 for 10 cycles with req_valid held high carrying a=8'h81, b=8'h85.
  - Required: rsp_x and rsp_sel stable, req_ready=0 throughout, second request not accepted. After rsp_ready=1, the second result is 8'h06.
- Back-to-back:
  - Stimulus: 15 requests with sel=0..14 and rsp_ready=1.
  - Required: responses in order with matching rsp_sel, op_count=15, spacing SETTLE_CYCLES+2 cycles.
- Counter wrap:
  - Stimulus: force op_count near 16'hFFFE via 2 ops after preload (or run 65537 ops).
  - Required: the sequence ...FFFF -> 0000 -> 0001.
